// File: rtl/tx_pkg.sv
// ----------------------------------------------------------------------------
// tx_pkg
// Definitions shared by the UART transmitter and its partner receiver:
//   - tx_state_e     : frame FSM state codes (IDLE/START/DATA/STOP)
//   - cycles_per_bit : clock cycles per line bit (integer division)
//   - count_width    : width of the bit-timing counter
// Both sides derive their timing from the same functions so they agree on
// the bit period.
// ----------------------------------------------------------------------------
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int cycles_per_bit(input int clock_hz, input int baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic int count_width(input int cycles, input int stop_bits);
        return 1 + $clog2(cycles * stop_bits);
    endfunction

endpackage

// File: rtl/tx_baud_timer.sv
// ----------------------------------------------------------------------------
// baud_timer
// Bit-period timer. Counts 0..CYCLES-1 and wraps; tick is high during the
// last cycle of each bit so the owner can advance on that edge.
// Ports:
//   clock   : system clock, posedge
//   reset   : synchronous, active-high
//   restart : hold the counter at 0 (used while the line is idle)
//   tick    : last cycle of the current bit period
// ----------------------------------------------------------------------------
module baud_timer #(
    parameter int CYCLES = 12,
    parameter int WIDTH  = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    logic [WIDTH-1:0] count_r;

    // Terminal count of the bit period.
    assign tick = (count_r == WIDTH'(CYCLES - 1));

    // Cycle counter: cleared on restart and on every bit boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (restart || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tx.sv
// ----------------------------------------------------------------------------
// tx
// UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first.
// A single-entry holding register takes the next byte while a frame is on
// the line, so consecutive frames leave with no idle gap.
// Ports:
//   clock : system clock, posedge
//   reset : synchronous, active-high; aborts any frame and drops a held byte
//   valid : producer offers a byte on data
//   data  : byte to send, sampled on the edge where valid && ready
//   ready : holding register empty (inverted holding-full flop)
//   pin   : serial line, idle high, driven from a flop
//   busy  : high from start bit through the last stop bit
// ----------------------------------------------------------------------------
module tx
    import tx_pkg::*;
#(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 12_000_000,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       pin,
    output logic       busy
);

    localparam int CPB = cycles_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam int CW  = count_width(CPB, STOP_BITS);

    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("tx: STOP_BITS must be 1 or 2");
    end
    if (CPB < 2) begin : g_bad_cycles
        $error("tx: CLOCK_HZ / BAUD_RATE must be at least 2");
    end

    tx_state_e  state_r, state_s;
    logic [7:0] shift_r, shift_s;
    logic [2:0] bit_idx_r, bit_idx_s;
    logic       stop_sub_r, stop_sub_s;
    logic [7:0] hold_r, hold_s;
    logic       hold_full_r, hold_full_s;
    logic       pin_r, pin_s;
    logic       busy_r, busy_s;
    logic       tick_s;
    logic       restart_s;

    // Timer is held at zero while idle so a new frame starts a fresh period.
    assign restart_s = (state_r == ST_IDLE);

    baud_timer #(
        .CYCLES (CPB),
        .WIDTH  (CW)
    ) u_baud_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state logic for the holding register and the frame FSM.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_idx_s   = bit_idx_r;
        stop_sub_s  = stop_sub_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        pin_s       = pin_r;
        busy_s      = busy_r;

        // Accept and load never coincide: accept needs the holding register
        // empty, load needs it full.
        if (valid && !hold_full_r) begin
            hold_s      = data;
            hold_full_s = 1'b1;
        end else begin
            hold_s      = hold_r;
        end

        case (state_r)
            ST_IDLE: begin
                pin_s  = 1'b1;
                busy_s = 1'b0;
                if (hold_full_r) begin
                    shift_s     = hold_r;
                    hold_full_s = 1'b0;
                    pin_s       = 1'b0;
                    busy_s      = 1'b1;
                    state_s     = ST_START;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    pin_s     = shift_r[0];
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    state_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_idx_r == 3'd7) begin
                        pin_s      = 1'b1;
                        bit_idx_s  = 3'd0;
                        stop_sub_s = 1'b0;
                        state_s    = ST_STOP;
                    end else begin
                        // Bit 0 of the shifter is always the bit on the line.
                        shift_s   = {1'b1, shift_r[7:1]};
                        pin_s     = shift_r[1];
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (stop_sub_r == 1'(STOP_BITS - 1)) begin
                        if (hold_full_r) begin
                            // Back-to-back frame: straight into the next start bit.
                            shift_s     = hold_r;
                            hold_full_s = 1'b0;
                            pin_s       = 1'b0;
                            state_s     = ST_START;
                        end else begin
                            pin_s   = 1'b1;
                            busy_s  = 1'b0;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        stop_sub_s = stop_sub_r + 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                pin_s   = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            stop_sub_r  <= 1'b0;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            pin_r       <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            bit_idx_r   <= bit_idx_s;
            stop_sub_r  <= stop_sub_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            pin_r       <= pin_s;
            busy_r      <= busy_s;
        end
    end

    assign ready = ~hold_full_r;
    assign pin   = pin_r;
    assign busy  = busy_r;

endmodule
